mac_beams_ctrl: RTL and testbench

MAC_BEAMS_CTRL -- requirements
Module: mac_beams_ctrl

---
 rtl/mac_beams_ctrl.sv | 143 ++++++++++++++
 tb/tb_mac_beams_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mac_beams_ctrl.sv
// Slot controller for the beam-MAC datapath. It paces upstream antenna beats per
// symbol and slot, and ping-pongs the two codeword banks between loader and MAC.
module mac_beams_ctrl #(
    parameter int NRB  = 132,
    parameter int NSYM = 14,
    parameter int LAT  = 12
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tvalid,
    output logic       o_tready,
    input  logic       i_cw_load_done,
    output logic       o_cw_wr_bank,
    output logic       o_cw_rd_bank,
    output logic       o_rvalid,
    output logic       o_sop,
    output logic       o_eop,
    output logic [3:0] o_sym_idx,
    output logic       o_slot_done,
    output logic       o_busy,
    output logic       o_err_ovf
);

    localparam int RW = $clog2(NRB);
    localparam int DW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   re_cnt;
    logic [3:0]      sym_cnt;
    logic [DW-1:0]   drain_cnt;
    logic [1:0]      cw_valid;
    logic [1:0]      cw_valid_rel;
    logic            rd_bank;
    logic            wr_bank;
    logic            accept;
    logic            last_re;
    logic            last_sym;
    logic            release_slot;
    logic            load_ok;

    assign accept       = i_tvalid && o_tready;
    assign last_re      = (re_cnt == RW'(NRB - 1));
    assign last_sym     = (sym_cnt == 4'(NSYM - 1));
    assign release_slot = (state == DRAIN) && (drain_cnt == DW'(LAT));

    assign o_cw_rd_bank = rd_bank;
    assign o_cw_wr_bank = wr_bank;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_nxt = state;
        o_tready  = 1'b0;
        o_busy    = 1'b1;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (cw_valid[rd_bank]) state_nxt = RUN;
            end
            RUN: begin
                o_tready = 1'b1;
                if (accept && last_re && last_sym) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (release_slot) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A slot release frees its bank before a same-cycle load is judged.
    always_comb begin
        cw_valid_rel = cw_valid;
        if (release_slot) cw_valid_rel[rd_bank] = 1'b0;
        load_ok = i_cw_load_done && !cw_valid_rel[wr_bank];
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            re_cnt    <= '0;
            sym_cnt   <= '0;
            o_rvalid  <= 1'b0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
            o_sym_idx <= '0;
        end else begin
            o_rvalid <= accept;
            o_sop    <= accept && (re_cnt == '0);
            o_eop    <= accept && last_re;
            if (accept) begin
                o_sym_idx <= sym_cnt;
                if (last_re) begin
                    re_cnt  <= '0;
                    sym_cnt <= last_sym ? 4'd0 : sym_cnt + 4'd1;
                end else begin
                    re_cnt <= re_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            drain_cnt   <= '0;
            o_slot_done <= 1'b0;
        end else begin
            o_slot_done <= release_slot;
            if (state == DRAIN && !release_slot) drain_cnt <= drain_cnt + 1'b1;
            else                                 drain_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cw_valid  <= 2'b00;
            rd_bank   <= 1'b0;
            wr_bank   <= 1'b0;
            o_err_ovf <= 1'b0;
        end else begin
            cw_valid <= cw_valid_rel;
            if (release_slot) rd_bank <= ~rd_bank;
            if (load_ok) begin
                cw_valid[wr_bank] <= 1'b1;
                wr_bank           <= ~wr_bank;
            end else if (i_cw_load_done) begin
                o_err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_beams_ctrl.sv
// Bench for mac_beams_ctrl: directed slot scenarios followed by random traffic,
// all compared every cycle against a beat-index based reference model.
module tb_mac_beams_ctrl;

    localparam int NRB  = 4;
    localparam int NSYM = 2;
    localparam int LAT  = 3;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_tvalid;
    logic       o_tready;
    logic       i_cw_load_done;
    logic       o_cw_wr_bank;
    logic       o_cw_rd_bank;
    logic       o_rvalid;
    logic       o_sop;
    logic       o_eop;
    logic [3:0] o_sym_idx;
    logic       o_slot_done;
    logic       o_busy;
    logic       o_err_ovf;

    mac_beams_ctrl #(.NRB(NRB), .NSYM(NSYM), .LAT(LAT)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_tvalid(i_tvalid), .o_tready(o_tready),
        .i_cw_load_done(i_cw_load_done), .o_cw_wr_bank(o_cw_wr_bank),
        .o_cw_rd_bank(o_cw_rd_bank), .o_rvalid(o_rvalid), .o_sop(o_sop), .o_eop(o_eop),
        .o_sym_idx(o_sym_idx), .o_slot_done(o_slot_done), .o_busy(o_busy),
        .o_err_ovf(o_err_ovf)
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc_no = 0;
    int last_rv_cyc = -1;
    int done_cyc    = -1;
    int done_count  = 0;

    // Reference model: mode 0=idle 1=run 2=drain; position tracked as beat index in slot
    bit known = 1'b0;
    int m_st, m_beat, m_wait;
    bit m_valid [2];
    bit m_rd, m_wr, m_err;
    bit e_rvalid, e_sop, e_eop, e_done;
    int e_sym;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
    endtask

    task automatic model_step(input bit rst, input bit tv, input bit ld);
        bit acc;
        if (rst) begin
            known = 1'b1;
            m_st = 0; m_beat = 0; m_wait = 0;
            m_valid[0] = 0; m_valid[1] = 0;
            m_rd = 0; m_wr = 0; m_err = 0;
            e_rvalid = 0; e_sop = 0; e_eop = 0; e_done = 0; e_sym = 0;
            return;
        end
        acc      = tv && (m_st == 1);
        e_rvalid = acc;
        e_sop    = acc && (m_beat % NRB == 0);
        e_eop    = acc && (m_beat % NRB == NRB - 1);
        if (acc) e_sym = m_beat / NRB;
        e_done   = 0;
        if (m_st == 0) begin
            if (m_valid[m_rd]) begin m_st = 1; m_beat = 0; end
        end else if (m_st == 1) begin
            if (acc) begin
                m_beat++;
                if (m_beat == NRB * NSYM) begin m_st = 2; m_wait = 0; end
            end
        end else begin
            if (m_wait == LAT) begin
                m_valid[m_rd] = 0;
                m_rd   = !m_rd;
                e_done = 1;
                m_st   = 0;
            end else begin
                m_wait++;
            end
        end
        if (ld) begin
            if (!m_valid[m_wr]) begin m_valid[m_wr] = 1; m_wr = !m_wr; end
            else m_err = 1;
        end
    endtask

    task automatic compare_all();
        if (!known) return;
        check("tready",  32'(o_tready),     32'(m_st == 1));
        check("busy",    32'(o_busy),       32'(m_st != 0));
        check("rd_bank", 32'(o_cw_rd_bank), 32'(m_rd));
        check("wr_bank", 32'(o_cw_wr_bank), 32'(m_wr));
        check("err_ovf", 32'(o_err_ovf),    32'(m_err));
        check("rvalid",  32'(o_rvalid),     32'(e_rvalid));
        check("sop",     32'(o_sop),        32'(e_sop));
        check("eop",     32'(o_eop),        32'(e_eop));
        check("sym_idx", 32'(o_sym_idx),    32'(e_sym));
        check("slot_dn", 32'(o_slot_done),  32'(e_done));
    endtask

    task automatic tick(input bit rst, input bit tv, input bit ld);
        @(negedge i_clk);
        compare_all();
        if (o_rvalid === 1'b1)    last_rv_cyc = cyc_no;
        if (o_slot_done === 1'b1) begin done_cyc = cyc_no; done_count++; end
        i_reset        = rst;
        i_tvalid       = tv;
        i_cw_load_done = ld;
        model_step(rst, tv, ld);
        cyc_no++;
    endtask

    initial begin
        int beats;
        i_reset = 1'b1; i_tvalid = 1'b0; i_cw_load_done = 1'b0;
        tick(1, 0, 0);
        tick(1, 0, 0);

        // Idle wait with no codewords: upstream must never be accepted
        repeat (20) tick(0, 1, 0);
        check("idle_tready", 32'(o_tready), 32'd0);
        check("idle_busy",   32'(o_busy),   32'd0);

        // Basic slot on bank 0
        tick(0, 0, 1);
        repeat (NRB * NSYM + LAT + 8) tick(0, 1, 0);
        check("slot_done_delay", 32'(done_cyc - last_rv_cyc), 32'(LAT + 1));
        check("rd_bank_after",   32'(o_cw_rd_bank), 32'd1);

        // Stall after beat 2 for five cycles, on bank 1
        tick(0, 0, 1);
        beats = 0;
        for (int i = 0; i < 60; i++) begin
            if (beats == 3 && i < 40) begin
                repeat (5) tick(0, 0, 0);
                beats++;
            end else begin
                if (m_st == 1) beats++;
                tick(0, 1, 0);
            end
        end
        check("stall_slot_done", 32'(done_count), 32'd2);

        // Reset on the fifth beat: slot aborted, no done pulse
        tick(1, 0, 0);
        tick(0, 0, 1);
        beats = 0;
        for (int i = 0; i < 40 && beats < 5; i++) begin
            if (m_st == 1) beats++;
            tick(0, 1, 0);
        end
        done_count = 0;
        tick(1, 0, 0);
        tick(0, 0, 0);
        check("abort_busy",    32'(o_busy),       32'd0);
        check("abort_rvalid",  32'(o_rvalid),     32'd0);
        check("abort_rd_bank", 32'(o_cw_rd_bank), 32'd0);
        repeat (10) tick(0, 1, 0);
        check("abort_no_done", 32'(done_count), 32'd0);

        // Three loads with no traffic: third overflows
        tick(1, 0, 0);
        repeat (3) tick(0, 0, 1);
        tick(0, 0, 0);
        check("ovf_flag",    32'(o_err_ovf),    32'd1);
        check("ovf_wr_bank", 32'(o_cw_wr_bank), 32'd0);

        // Load coinciding with the drain release of bank 0
        tick(1, 0, 0);
        tick(0, 0, 1);
        tick(0, 0, 1);
        for (int i = 0; i < 40; i++) tick(0, 1, (m_st == 2 && m_wait == LAT && i < 20));
        check("simul_no_ovf", 32'(o_err_ovf), 32'd0);

        // Random traffic, loads and occasional resets
        tick(1, 0, 0);
        for (int i = 0; i < 3000; i++)
            tick(($urandom % 500) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0);
        tick(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
